// File: rtl/monster_wave_pkg.sv
// rtl/monster_wave_pkg.sv - shared types and slot helpers for the monster wave controller
package monster_wave_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        CLEARED = 2'd2,
        LANDED  = 2'd3
    } wave_state_t;

    localparam int COORD_W = 11;

    function automatic int slot_row(input int idx, input int cols);
        return idx / cols;
    endfunction

    function automatic int slot_col(input int idx, input int cols);
        return idx % cols;
    endfunction

endpackage

// File: rtl/monster_wave_controller_if.sv
// rtl/monster_wave_controller_if.sv - game-side bus of the monster wave controller
interface monster_wave_controller_if #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
);
    import monster_wave_pkg::*;

    logic                       enable;
    logic                       startOfFrame;
    logic                       start_wave;
    logic                       hit_valid;
    logic [IDX_W-1:0]           hit_index;
    logic signed [COORD_W-1:0]  topLeftX;
    logic signed [COORD_W-1:0]  topLeftY;
    logic [N-1:0]               alive_mask;
    logic [N-1:0]               dying_mask;
    logic                       shoot_pulse;
    logic [IDX_W-1:0]           shooter_index;
    logic                       monster_died_pulse;
    logic [IDX_W:0]             died_count;
    logic                       all_monsters_dead;
    logic                       landed;
    logic [7:0]                 wave_number;

    modport master (
        output enable, startOfFrame, start_wave, hit_valid, hit_index,
        input  topLeftX, topLeftY, alive_mask, dying_mask, shoot_pulse, shooter_index,
               monster_died_pulse, died_count, all_monsters_dead, landed, wave_number
    );

    modport slave (
        input  enable, startOfFrame, start_wave, hit_valid, hit_index,
        output topLeftX, topLeftY, alive_mask, dying_mask, shoot_pulse, shooter_index,
               monster_died_pulse, died_count, all_monsters_dead, landed, wave_number
    );

endinterface

// File: rtl/monster_wave_controller_rr_slot_picker.sv
// rtl/monster_wave_controller_rr_slot_picker.sv - first requesting slot after a pointer, wrapping
module rr_slot_picker #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] index,
    output logic             found
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/monster_wave_controller.sv
// rtl/monster_wave_controller.sv - formation state, marching, shooting and wave sequencing
module monster_wave_controller
    import monster_wave_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int X_SPACING      = 128,
    parameter int Y_SPACING      = 64,
    parameter int MONSTER_W      = 32,
    parameter int INITIAL_X      = 100,
    parameter int INITIAL_Y      = 50,
    parameter int X_STEP         = 4,
    parameter int Y_STEP         = 16,
    parameter int MOVE_PERIOD    = 2,
    parameter int LEFT_BOUND     = 0,
    parameter int RIGHT_BOUND    = 639,
    parameter int BOTTOM_BOUND   = 400,
    parameter int DEATH_FRAMES   = 10,
    parameter int SHOOT_COOLDOWN = 60
) (
    input  logic                    clk,
    input  logic                    reset,
    monster_wave_controller_if.slave bus
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = $clog2(N);
    localparam int EXT_W = COORD_W + 1;
    localparam int DC_W  = $clog2(DEATH_FRAMES + 1);
    localparam int MC_W  = $clog2(MOVE_PERIOD + 1);
    localparam int CD_W  = $clog2(SHOOT_COOLDOWN + 1);

    wave_state_t state, state_next;

    logic signed [COORD_W-1:0] pos_x, pos_y;
    logic                      dir_right;
    logic [N-1:0]              alive, dying, expiring, eligible;
    logic [DC_W-1:0]           death_cnt [N];
    logic [MC_W-1:0]           move_cnt;
    logic [CD_W-1:0]           cooldown;
    logic [IDX_W-1:0]          rr_ptr, pick_index, shooter_index;
    logic                      pick_found, shoot_pulse, died_pulse;
    logic [IDX_W:0]            died_count, expire_count;
    logic [7:0]                wave_number;

    logic                      tick_act, wave_start, hit_ok, move_due, blocked, drop, land;
    int                        min_col, max_col, max_row;
    logic signed [EXT_W-1:0]   x_ext, y_ext, right_edge, left_edge, x_moved, y_drop, bottom_new;

    assign tick_act   = bus.startOfFrame && bus.enable && (state == ACTIVE);
    assign wave_start = bus.start_wave && (state != ACTIVE);
    assign eligible   = alive & ~dying;

    always_comb begin
        expire_count = '0;
        for (int i = 0; i < N; i++) begin
            expiring[i]  = tick_act && (death_cnt[i] == DC_W'(1));
            expire_count = expire_count + (IDX_W+1)'(expiring[i]);
        end
    end

    // An expiring slot is still marked dying, so the dying test also rejects it.
    assign hit_ok = bus.hit_valid && (state == ACTIVE) && (int'(bus.hit_index) < N)
                    && alive[bus.hit_index] && !dying[bus.hit_index] && !expiring[bus.hit_index];

    always_comb begin
        min_col = COLS - 1;
        max_col = 0;
        max_row = 0;
        for (int i = 0; i < N; i++) begin
            if (alive[i]) begin
                if (slot_col(i, COLS) < min_col) min_col = slot_col(i, COLS);
                if (slot_col(i, COLS) > max_col) max_col = slot_col(i, COLS);
                if (slot_row(i, COLS) > max_row) max_row = slot_row(i, COLS);
            end
        end
    end

    always_comb begin
        x_ext      = {pos_x[COORD_W-1], pos_x};
        y_ext      = {pos_y[COORD_W-1], pos_y};
        right_edge = x_ext + $signed(EXT_W'(max_col * X_SPACING + MONSTER_W - 1));
        left_edge  = x_ext + $signed(EXT_W'(min_col * X_SPACING));
        x_moved    = dir_right ? x_ext + $signed(EXT_W'(X_STEP)) : x_ext - $signed(EXT_W'(X_STEP));
        y_drop     = y_ext + $signed(EXT_W'(Y_STEP));
        bottom_new = y_drop + $signed(EXT_W'(max_row * Y_SPACING + MONSTER_W - 1));
        blocked    = dir_right
                   ? (right_edge + $signed(EXT_W'(X_STEP)) > $signed(EXT_W'(RIGHT_BOUND)))
                   : (left_edge - $signed(EXT_W'(X_STEP)) < $signed(EXT_W'(LEFT_BOUND)));
        move_due   = (move_cnt == MC_W'(MOVE_PERIOD - 1));
        drop       = tick_act && move_due && blocked;
        land       = drop && (bottom_new >= $signed(EXT_W'(BOTTOM_BOUND)));
    end

    rr_slot_picker #(.N(N), .IDX_W(IDX_W)) u_shoot_picker (
        .req   (eligible),
        .ptr   (rr_ptr),
        .index (pick_index),
        .found (pick_found)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ACTIVE: begin
                if (alive == '0) state_next = CLEARED;
                else if (land)   state_next = LANDED;
            end
            default: begin
                if (bus.start_wave) state_next = ACTIVE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pos_x         <= COORD_W'(INITIAL_X);
            pos_y         <= COORD_W'(INITIAL_Y);
            dir_right     <= 1'b1;
            alive         <= '0;
            dying         <= '0;
            move_cnt      <= '0;
            cooldown      <= '0;
            rr_ptr        <= '0;
            shooter_index <= '0;
            shoot_pulse   <= 1'b0;
            died_pulse    <= 1'b0;
            died_count    <= '0;
            wave_number   <= '0;
            for (int i = 0; i < N; i++) death_cnt[i] <= '0;
        end else begin
            shoot_pulse <= 1'b0;
            died_pulse  <= 1'b0;
            died_count  <= '0;
            if (wave_start) begin
                alive       <= '1;
                dying       <= '0;
                pos_x       <= COORD_W'(INITIAL_X);
                pos_y       <= COORD_W'(INITIAL_Y);
                dir_right   <= 1'b1;
                move_cnt    <= '0;
                cooldown    <= CD_W'(SHOOT_COOLDOWN);
                rr_ptr      <= IDX_W'(N - 1);
                wave_number <= wave_number + 8'd1;
                for (int i = 0; i < N; i++) death_cnt[i] <= '0;
            end else if (state == ACTIVE) begin
                for (int i = 0; i < N; i++) begin
                    if (expiring[i]) begin
                        alive[i] <= 1'b0;
                        dying[i] <= 1'b0;
                    end
                    if (tick_act && death_cnt[i] != '0) death_cnt[i] <= death_cnt[i] - DC_W'(1);
                end
                if (hit_ok) begin
                    dying[bus.hit_index]     <= 1'b1;
                    death_cnt[bus.hit_index] <= DC_W'(DEATH_FRAMES);
                end
                died_pulse <= |expiring;
                died_count <= expire_count;
                if (tick_act) begin
                    if (move_due) begin
                        move_cnt <= '0;
                        if (drop) begin
                            pos_y     <= y_drop[COORD_W-1:0];
                            dir_right <= !dir_right;
                        end else begin
                            pos_x <= x_moved[COORD_W-1:0];
                        end
                    end else begin
                        move_cnt <= move_cnt + MC_W'(1);
                    end
                    // Shot selection sees the masks as registered, before this cycle's hit.
                    if (cooldown <= CD_W'(1)) begin
                        cooldown <= CD_W'(SHOOT_COOLDOWN);
                        if (pick_found) begin
                            shoot_pulse   <= 1'b1;
                            shooter_index <= pick_index;
                            rr_ptr        <= pick_index;
                        end
                    end else begin
                        cooldown <= cooldown - CD_W'(1);
                    end
                end
            end
        end
    end

    assign bus.topLeftX           = pos_x;
    assign bus.topLeftY           = pos_y;
    assign bus.alive_mask         = alive;
    assign bus.dying_mask         = dying;
    assign bus.shoot_pulse        = shoot_pulse;
    assign bus.shooter_index      = shooter_index;
    assign bus.monster_died_pulse = died_pulse;
    assign bus.died_count         = died_count;
    assign bus.all_monsters_dead  = (state == CLEARED);
    assign bus.landed             = (state == LANDED);
    assign bus.wave_number        = wave_number;

endmodule

// File: tb/tb_monster_wave_controller.sv
// tb/tb_monster_wave_controller.sv - directed self-checking bench for monster_wave_controller
module tb_monster_wave_controller;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    monster_wave_controller_if #(.N(16)) bus();

    monster_wave_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bus.startOfFrame = 1'b1;
        step();
        bus.startOfFrame = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        repeat (n) begin
            tick();
            step();
        end
    endtask

    task automatic hit(input int idx);
        bus.hit_valid = 1'b1;
        bus.hit_index = 4'(idx);
        step();
        bus.hit_valid = 1'b0;
    endtask

    task automatic start();
        bus.start_wave = 1'b1;
        step();
        bus.start_wave = 1'b0;
    endtask

    task automatic do_reset();
        reset            = 1'b1;
        bus.enable       = 1'b1;
        bus.startOfFrame = 1'b0;
        bus.start_wave   = 1'b0;
        bus.hit_valid    = 1'b0;
        bus.hit_index    = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    int n_shots;

    initial begin
        do_reset();
        check("rst_alive", bus.alive_mask, 0);
        check("rst_dying", bus.dying_mask, 0);
        check("rst_x", bus.topLeftX, 100);
        check("rst_y", bus.topLeftY, 50);
        check("rst_wave", bus.wave_number, 0);
        check("rst_shoot", bus.shoot_pulse, 0);
        check("rst_died", bus.monster_died_pulse, 0);
        check("rst_landed", bus.landed, 0);
        check("rst_cleared", bus.all_monsters_dead, 0);

        start();
        check("start_alive", bus.alive_mask, 32'hFFFF);
        check("start_x", bus.topLeftX, 100);
        check("start_y", bus.topLeftY, 50);
        check("start_wave", bus.wave_number, 1);

        for (int i = 0; i < 16; i++) hit(i);
        check("all_hit_dying", bus.dying_mask, 32'hFFFF);
        run_ticks(9);
        check("all_hit_pre_died", bus.monster_died_pulse, 0);
        tick();
        check("all_died_pulse", bus.monster_died_pulse, 1);
        check("all_died_count", bus.died_count, 16);
        check("all_died_alive", bus.alive_mask, 0);
        check("all_died_not_yet_cleared", bus.all_monsters_dead, 0);
        step();
        check("cleared", bus.all_monsters_dead, 1);
        check("died_pulse_one_cycle", bus.monster_died_pulse, 0);

        bus.hit_valid  = 1'b1;
        bus.hit_index  = 4'd3;
        bus.start_wave = 1'b1;
        step();
        bus.hit_valid  = 1'b0;
        bus.start_wave = 1'b0;
        check("restart_alive", bus.alive_mask, 32'hFFFF);
        check("restart_hit_dropped", bus.dying_mask, 0);
        check("restart_wave", bus.wave_number, 2);
        check("restart_not_cleared", bus.all_monsters_dead, 0);

        hit(5);
        check("hit5_dying", bus.dying_mask, 32'h0020);
        hit(5);
        check("rehit5_dying", bus.dying_mask, 32'h0020);
        run_ticks(9);
        check("hit5_pre_died", bus.monster_died_pulse, 0);
        check("hit5_pre_alive", bus.alive_mask, 32'hFFFF);
        tick();
        check("hit5_died_pulse", bus.monster_died_pulse, 1);
        check("hit5_died_count", bus.died_count, 1);
        check("hit5_alive", bus.alive_mask, 32'hFFDF);
        check("hit5_dying_clear", bus.dying_mask, 0);
        step();
        check("hit5_pulse_gone", bus.monster_died_pulse, 0);
        hit(5);
        check("hit_dead5", bus.dying_mask, 0);

        run_ticks(49);
        check("march_t59_x", bus.topLeftX, 216);
        check("march_t59_noshot", bus.shoot_pulse, 0);
        tick();
        check("shot_t60", bus.shoot_pulse, 1);
        check("shot_t60_idx", bus.shooter_index, 0);
        check("march_t60_x", bus.topLeftX, 220);
        step();
        check("shot_one_cycle", bus.shoot_pulse, 0);
        run_ticks(2);
        check("march_t62_x", bus.topLeftX, 224);
        check("march_t62_y", bus.topLeftY, 50);
        run_ticks(2);
        check("drop_x", bus.topLeftX, 224);
        check("drop_y", bus.topLeftY, 66);
        run_ticks(2);
        check("left_x", bus.topLeftX, 220);
        check("left_y", bus.topLeftY, 66);

        do_reset();
        start();
        hit(1);
        hit(2);
        bus.enable = 1'b0;
        n_shots = 0;
        for (int t = 0; t < 70; t++) begin
            tick();
            if (bus.shoot_pulse) n_shots++;
            step();
        end
        check("noen_shots", n_shots, 0);
        check("noen_x", bus.topLeftX, 100);
        check("noen_dying", bus.dying_mask, 32'h0006);
        bus.enable = 1'b1;
        n_shots = 0;
        for (int t = 1; t <= 180; t++) begin
            tick();
            if (bus.shoot_pulse) n_shots++;
            if (t == 60)  check("rr_shot60_idx", bus.shooter_index, 0);
            if (t == 120) check("rr_shot120_idx", bus.shooter_index, 3);
            if (t == 180) check("rr_shot180_idx", bus.shooter_index, 4);
            if (t % 60 == 0) check("rr_shot_pulse", bus.shoot_pulse, 1);
            step();
        end
        check("rr_shot_total", n_shots, 3);
        check("rr_idx_held", bus.shooter_index, 4);

        do_reset();
        start();
        run_ticks(861);
        check("preland_landed", bus.landed, 0);
        check("preland_y", bus.topLeftY, 162);
        check("preland_x", bus.topLeftX, 0);
        tick();
        check("land_landed", bus.landed, 1);
        check("land_y", bus.topLeftY, 178);
        check("land_x", bus.topLeftX, 0);
        step();
        run_ticks(4);
        check("land_frozen_x", bus.topLeftX, 0);
        check("land_frozen_y", bus.topLeftY, 178);
        check("land_still", bus.landed, 1);
        start();
        check("reland_landed", bus.landed, 0);
        check("reland_wave", bus.wave_number, 2);
        check("reland_x", bus.topLeftX, 100);
        check("reland_y", bus.topLeftY, 50);
        check("reland_alive", bus.alive_mask, 32'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
